// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the fetch front end and the control unit
package riscv_pkg;

    localparam int          PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with registered storage, flush, and occupancy count
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 96,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // pointers and occupancy; flush and reset clear everything, a pop frees its slot for a same-cycle push
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage write; contents need no reset because dout is masked while empty
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, credit-limited in-order imem requests, response buffering and redirect flush
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
    parameter int                  FIFO_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [WORDSIZE-1:0]         imem_req_addr,
    input  logic                        imem_resp_valid,
    input  logic [INSTRUCTION_SIZE-1:0] imem_resp_data,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic [WORDSIZE-1:0]         instr_pc
);

    localparam int                  CW   = $clog2(2 * FIFO_DEPTH) + 1;
    localparam int                  FW   = $clog2(FIFO_DEPTH) + 1;
    localparam int                  EW   = WORDSIZE + INSTRUCTION_SIZE;
    localparam logic [WORDSIZE-1:0] STEP = WORDSIZE'(PC_STEP);

    logic [WORDSIZE-1:0] pc;
    logic [WORDSIZE-1:0] resp_pc;
    logic [WORDSIZE-1:0] target;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       outstanding_next;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       live;
    logic [FW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                req_fire;
    logic                resp_ok;
    logic                push;
    logic                pop;
    logic [EW-1:0]       fifo_dout;

    // live counts only in-flight requests whose data will actually be kept
    assign live             = outstanding - drop_cnt;
    assign imem_req_valid   = !rst
                              && ((CW+1)'(fifo_count) + (CW+1)'(live) < (CW+1)'(FIFO_DEPTH))
                              && (outstanding < CW'(2 * FIFO_DEPTH));
    assign imem_req_addr    = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign resp_ok          = imem_resp_valid && !rst && outstanding != '0;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_ok);
    assign push             = resp_ok && drop_cnt == '0 && !redirect_valid;
    assign pop              = instr_valid && instr_ready && !redirect_valid;
    assign target           = redirect_pc & ~WORDSIZE'(PC_STEP - 1);
    assign instr_valid      = !fifo_empty;
    assign instruction      = fifo_dout[INSTRUCTION_SIZE-1:0];
    assign instr_pc         = fifo_dout[EW-1:INSTRUCTION_SIZE];

    // fetch/response PCs and in-flight bookkeeping; a redirect marks everything still in flight as stale
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            pc          <= redirect_valid ? target : req_fire ? pc + STEP : pc;
            resp_pc     <= redirect_valid ? target : push ? resp_pc + STEP : resp_pc;
            drop_cnt    <= redirect_valid ? outstanding_next
                         : (resp_ok && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({resp_pc, imem_resp_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // simulation checks: no response without a request, and the credit rule never overfills the buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && outstanding == '0));
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table vectors, directed corner sequences and randomized scoreboard for instruction_fetch
module tb_instruction_fetch;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [63:0] instr_pc;

    always #5 clk = ~clk;

    instruction_fetch #(
        .WORDSIZE         (64),
        .INSTRUCTION_SIZE (32),
        .RESET_PC         (RESET_PC),
        .FIFO_DEPTH       (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc)
    );

    typedef struct {
        int unsigned due;
        logic [63:0] addr;
    } req_t;

    typedef struct {
        logic        rr;
        logic        ir;
        logic        rv;
        logic [63:0] addr;
        logic        iv;
        logic [63:0] pc;
    } vec_t;

    req_t        pending[$];
    vec_t        tbl[22];
    int unsigned cycle = 0;
    int unsigned lat = 1;
    int          npops = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_pc = RESET_PC;
    logic [63:0] fetch_pc = RESET_PC;
    logic [63:0] last_pc = '0;

    function automatic logic [31:0] word(logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
    endfunction

    function automatic vec_t v(int rr, int ir, int rv, int addr, int iv, int pc);
        vec_t r;
        r.rr = rr != 0;
        r.ir = ir != 0;
        r.rv = rv != 0;
        r.addr = 64'(addr);
        r.iv = iv != 0;
        r.pc = 64'(pc);
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // one clock: memory model, in-order scoreboard and hold checks around the edge
    task automatic cyc();
        logic hold;
        logic ahold;
        #1;
        if (!rst && imem_req_valid) chk("req_addr", imem_req_addr, fetch_pc);
        if (imem_req_valid && imem_req_ready) pending.push_back('{cycle + lat, imem_req_addr});
        if (imem_resp_valid) void'(pending.pop_front());
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", {32'h0, instruction}, {32'h0, word(exp_pc)});
            last_pc = instr_pc;
            exp_pc += 64'd4;
            npops++;
        end
        hold = !rst && instr_valid && !instr_ready && !redirect_valid;
        ahold = !rst && imem_req_valid && !imem_req_ready && !redirect_valid;
        if (!rst && redirect_valid) begin
            exp_pc = redirect_pc & ~64'd3;
            fetch_pc = redirect_pc & ~64'd3;
        end else if (!rst && imem_req_valid && imem_req_ready) begin
            fetch_pc += 64'd4;
        end
        @(posedge clk);
        #1;
        cycle++;
        redirect_valid = 1'b0;
        if (hold) begin
            chk("hold_valid", instr_valid, 1);
            chk("hold_pc", instr_pc, exp_pc);
            chk("hold_instr", {32'h0, instruction}, {32'h0, word(exp_pc)});
        end
        if (ahold) chk("req_hold_valid", imem_req_valid, 1);
        imem_resp_valid = pending.size() > 0 && pending[0].due == cycle;
        imem_resp_data = imem_resp_valid ? word(pending[0].addr) : '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        cyc();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instruction", {32'h0, instruction}, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        for (int i = 0; i < 10 && pending.size() > 0; i++) cyc();
        cyc();
        rst = 1'b0;
        exp_pc = RESET_PC;
        fetch_pc = RESET_PC;
    endtask

    task automatic wait_pops(int n, int bound, string name);
        int target;
        target = npops + n;
        for (int i = 0; i < bound && npops < target; i++) cyc();
        chk(name, 64'(npops), 64'(target));
    endtask

    initial begin
        // zero-wait startup (credit limit gives two instructions per three cycles), then a 10-cycle decode stall
        tbl[0]  = v(1, 1, 1, 0,  0, 0);
        tbl[1]  = v(1, 1, 1, 4,  0, 0);
        tbl[2]  = v(1, 1, 0, 8,  1, 0);
        tbl[3]  = v(1, 1, 1, 8,  1, 4);
        tbl[4]  = v(1, 1, 1, 12, 0, 0);
        tbl[5]  = v(1, 1, 0, 16, 1, 8);
        tbl[6]  = v(1, 1, 1, 16, 1, 12);
        tbl[7]  = v(1, 0, 1, 20, 0, 0);
        for (int k = 8; k <= 16; k++) tbl[k] = v(1, 0, 0, 24, 1, 16);
        tbl[17] = v(1, 1, 0, 24, 1, 16);
        tbl[18] = v(1, 1, 1, 24, 1, 20);
        tbl[19] = v(1, 1, 1, 28, 0, 0);
        tbl[20] = v(1, 1, 0, 32, 1, 24);
        tbl[21] = v(1, 1, 1, 32, 1, 28);

        do_reset();
        lat = 1;
        for (int k = 0; k < 22; k++) begin
            imem_req_ready = tbl[k].rr;
            instr_ready = tbl[k].ir;
            #1;
            chk($sformatf("t%0d_req_valid", k), imem_req_valid, tbl[k].rv);
            chk($sformatf("t%0d_req_addr", k), imem_req_addr, tbl[k].addr);
            chk($sformatf("t%0d_instr_valid", k), instr_valid, tbl[k].iv);
            if (tbl[k].iv) chk($sformatf("t%0d_instr_pc", k), instr_pc, tbl[k].pc);
            cyc();
        end

        // 3-cycle memory, two requests in flight, redirect to 0x100
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        cyc();
        chk("redir_req_valid", imem_req_valid, 1);
        chk("redir_req_addr", imem_req_addr, 64'h100);
        wait_pops(1, 40, "redir_first_timeout");
        chk("redir_first_pc", last_pc, 64'h100);
        wait_pops(1, 40, "redir_second_timeout");
        chk("redir_second_pc", last_pc, 64'h104);

        // misaligned redirect coinciding with a response and a request handshake
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 64'h203;
        #1;
        chk("mis_req_valid_in_redirect", imem_req_valid, 1);
        chk("mis_resp_in_redirect", imem_resp_valid, 1);
        cyc();
        chk("mis_req_addr", imem_req_addr, 64'h200);
        chk("mis_req_valid", imem_req_valid, 1);
        chk("mis_iv_c2", instr_valid, 0);
        cyc();
        chk("mis_iv_c3", instr_valid, 0);
        cyc();
        chk("mis_iv_c4", instr_valid, 1);
        chk("mis_pc_c4", instr_pc, 64'h200);
        wait_pops(2, 40, "mis_timeout");
        chk("mis_second_pc", last_pc, 64'h204);

        // reset with a buffered instruction and a response still in flight
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        repeat (4) cyc();
        chk("pre_rst_valid", instr_valid, 1);
        chk("pre_rst_resp_pending", imem_resp_valid, 1);
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        wait_pops(3, 60, "post_rst_timeout");
        chk("post_rst_third_pc", last_pc, 64'h8);

        // randomized handshakes and redirects against the in-order scoreboard
        for (int phase = 0; phase < 2; phase++) begin
            int target;
            do_reset();
            lat = (phase == 0) ? 2 : 1;
            target = npops + ((phase == 0) ? 1000 : 400);
            for (int i = 0; i < 30000 && npops < target; i++) begin
                imem_req_ready = 1'($urandom_range(0, 1));
                instr_ready = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 63) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc = ($urandom_range(0, 3) == 0)
                                  ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))}
                                  : 64'($urandom);
                end
                cyc();
            end
            chk($sformatf("rand%0d_pops", phase), 64'(npops), 64'(target));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
